// File: rtl/serdes_frame_pkg.sv
// Framing constants and FSM state shared by the serializer-feed blocks.
package serdes_frame_pkg;

   localparam logic [31:0] IDLE_WORD = 32'h3C3C_3C3C;
   localparam logic [31:0] SOF_WORD  = 32'hFCFC_FCFC;
   localparam logic [15:0] EOF_TAG   = 16'hDCDC;
   localparam logic [15:0] PAD_HALF  = 16'h3C3C;

   typedef enum logic [1:0] {IDLE, DATA, EOF} frame_state_e;

endpackage

// File: rtl/serial_word_framer_if.sv
// Halfword input stream plus framed word output toward the serializer.
interface serial_word_framer_if;

   logic [15:0] hw_data;
   logic        hw_valid;
   logic        hw_last;
   logic        hw_ready;
   logic [31:0] data_out;
   logic        data_v;
   logic        underrun;
   logic        pkt_done;

   modport master (
      output hw_data, hw_valid, hw_last,
      input  hw_ready, data_out, data_v, underrun, pkt_done
   );

   modport slave (
      input  hw_data, hw_valid, hw_last,
      output hw_ready, data_out, data_v, underrun, pkt_done
   );

endinterface

// File: rtl/serial_word_framer_timer.sv
// Word slot timer: counts 0..WORD_PERIOD-1 while enabled, tick on the last count.
module word_period_timer #(
   parameter int WORD_PERIOD = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int CW = $clog2(WORD_PERIOD);
   localparam logic [CW-1:0] LAST = CW'(WORD_PERIOD - 1);

   logic [CW-1:0] cnt;

   assign tick = enable && (cnt == LAST);

   // Explicit wrap so non-power-of-two periods work.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (enable)
         cnt <= tick ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/serial_word_framer.sv
// Pairs packet halfwords into 32-bit words and frames them with SOF/EOF at a fixed word rate.
module serial_word_framer
   import serdes_frame_pkg::*;
#(
   parameter int WORD_PERIOD = 8,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   serial_word_framer_if.slave  bus
);

   logic             tick;
   frame_state_e     state, state_d;
   logic [31:0]      buf_q;
   logic [1:0]       fill;
   logic             asm_last;
   logic [CNT_W-1:0] hw_cnt;
   logic             accept;

   logic [31:0]      word_d;
   logic             underrun_d, pkt_done_d, clr_buf, clr_cnt;

   word_period_timer #(.WORD_PERIOD(WORD_PERIOD)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

   // Closed on tick so an accept can never race the buffer clear.
   assign bus.hw_ready = !reset && enable && !tick && (fill < 2'd2) && !asm_last && (state != EOF);
   assign accept       = bus.hw_valid && bus.hw_ready;

   // Word choice for the next slot; only applied when tick is high.
   always_comb begin
      state_d    = state;
      word_d     = IDLE_WORD;
      underrun_d = 1'b0;
      pkt_done_d = 1'b0;
      clr_buf    = 1'b0;
      clr_cnt    = 1'b0;
      case (state)
         IDLE: begin
            if (fill != 2'd0) begin
               word_d  = SOF_WORD;
               state_d = DATA;
            end
         end
         DATA: begin
            if (fill == 2'd2) begin
               word_d  = buf_q;
               clr_buf = 1'b1;
               if (asm_last) state_d = EOF;
            end else if (fill == 2'd1 && asm_last) begin
               word_d  = {buf_q[31:16], PAD_HALF};
               clr_buf = 1'b1;
               state_d = EOF;
            end else begin
               underrun_d = 1'b1;
            end
         end
         EOF: begin
            word_d     = {EOF_TAG, 16'(hw_cnt)};
            pkt_done_d = 1'b1;
            clr_cnt    = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else if (tick)
         state <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.data_out <= IDLE_WORD;
         bus.data_v   <= 1'b0;
         bus.underrun <= 1'b0;
         bus.pkt_done <= 1'b0;
         buf_q        <= '0;
         fill         <= 2'd0;
         asm_last     <= 1'b0;
         hw_cnt       <= '0;
      end else begin
         bus.data_v   <= tick;
         bus.underrun <= tick && underrun_d;
         bus.pkt_done <= tick && pkt_done_d;
         if (tick) begin
            bus.data_out <= word_d;
            if (clr_buf) begin
               buf_q    <= '0;
               fill     <= 2'd0;
               asm_last <= 1'b0;
            end
            if (clr_cnt) hw_cnt <= '0;
         end else if (accept) begin
            if (fill == 2'd0)
               buf_q[31:16] <= bus.hw_data;
            else
               buf_q[15:0]  <= bus.hw_data;
            fill <= fill + 2'd1;
            if (hw_cnt != '1) hw_cnt <= hw_cnt + 1'b1;
            if (bus.hw_last) asm_last <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_word_framer.sv
// Bench for serial_word_framer: queue-based framing model checked every cycle, plus literal word sequences.
module tb_serial_word_framer;
   import serdes_frame_pkg::*;

   localparam int WP = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;

   serial_word_framer_if bus();

   serial_word_framer #(.WORD_PERIOD(WP), .CNT_W(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: pending halfwords as a queue, packet phase 0=idle 1=data 2=eof.
   int          m_cnt = 0, m_phase = 0, m_count = 0;
   bit          m_last = 0;
   logic [15:0] hq[$];
   logic [31:0] m_word = IDLE_WORD;
   bit          m_v = 0, m_und = 0, m_pd = 0;

   logic [31:0] seen[$];
   int          strobes = 0, pkt_cnt = 0, und_cnt = 0;
   logic [31:0] last_pkt_word = '0;

   always @(negedge clk) begin
      bit tk, rdy;
      if (reset) begin
         m_cnt = 0; m_phase = 0; m_count = 0; m_last = 0; hq.delete();
         m_word = IDLE_WORD; m_v = 0; m_und = 0; m_pd = 0;
      end
      tk  = enable && (m_cnt == WP - 1);
      rdy = !reset && enable && !tk && (hq.size() < 2) && !m_last && (m_phase != 2);
      chk("hw_ready", 32'(bus.hw_ready), 32'(rdy));
      chk("data_v",   32'(bus.data_v),   32'(m_v));
      chk("data_out", bus.data_out,      m_word);
      chk("underrun", 32'(bus.underrun), 32'(m_und));
      chk("pkt_done", 32'(bus.pkt_done), 32'(m_pd));
      if (bus.data_v) begin
         strobes++;
         if (bus.data_out != IDLE_WORD) seen.push_back(bus.data_out);
      end
      if (bus.pkt_done) begin
         pkt_cnt++;
         last_pkt_word = bus.data_out;
      end
      if (bus.underrun) und_cnt++;
      if (!reset) begin
         m_v = 0; m_und = 0; m_pd = 0;
         if (tk) begin
            m_v = 1;
            m_word = IDLE_WORD;
            if (m_phase == 0) begin
               if (hq.size() > 0) begin m_word = SOF_WORD; m_phase = 1; end
            end else if (m_phase == 1) begin
               if (hq.size() == 2) begin
                  m_word = {hq[0], hq[1]};
                  hq.delete();
                  if (m_last) m_phase = 2;
                  m_last = 0;
               end else if (hq.size() == 1 && m_last) begin
                  m_word = {hq[0], PAD_HALF};
                  hq.delete();
                  m_last = 0;
                  m_phase = 2;
               end else begin
                  m_und = 1;
               end
            end else begin
               m_word = {EOF_TAG, 16'(m_count)};
               m_pd = 1;
               m_count = 0;
               m_phase = 0;
            end
         end else if (rdy && bus.hw_valid) begin
            hq.push_back(bus.hw_data);
            if (m_count < 65535) m_count++;
            if (bus.hw_last) m_last = 1;
         end
         if (enable) m_cnt = (m_cnt + 1) % WP;
      end
   end

   task automatic send(input logic [15:0] d, input bit l);
      int n = 0;
      bit done = 0;
      bus.hw_data = d; bus.hw_valid = 1'b1; bus.hw_last = l;
      while (!done && n < 200) begin
         @(negedge clk);
         done = bus.hw_ready;
         @(posedge clk);
         #1;
         n++;
      end
      bus.hw_valid = 1'b0; bus.hw_last = 1'b0;
      chk("send_accept", 32'(done), 32'd1);
   endtask

   task automatic wait_strobe();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.data_v && n < 40);
      chk("strobe_seen", 32'(bus.data_v), 32'd1);
   endtask

   task automatic chk_seq(input string nm, input int b, input int n,
                          input logic [31:0] e0, e1, e2, e3);
      logic [31:0] e[4];
      e = '{e0, e1, e2, e3};
      chk({nm, "_len"}, 32'(seen.size() - b), 32'(n));
      for (int i = 0; i < n; i++)
         chk(nm, (b + i < seen.size()) ? seen[b + i] : 'x, e[i]);
   endtask

   initial begin
      int b, p, u, s;
      bus.hw_data = '0; bus.hw_valid = 1'b0; bus.hw_last = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rst_data_out", bus.data_out, IDLE_WORD);
      chk("rst_data_v",   32'(bus.data_v), 32'd0);
      chk("rst_hw_ready", 32'(bus.hw_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0; enable = 1'b1;
      s = strobes;
      repeat (33) @(posedge clk);
      #1;
      chk("idle_strobes", 32'(strobes - s), 32'd4);
      chk("idle_no_frames", 32'(seen.size()), 32'd0);
      chk("ready_after_reset", 32'(bus.hw_ready), 32'd1);

      // Four halfwords back to back.
      b = seen.size(); p = pkt_cnt;
      send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 0); send(16'h4444, 1);
      repeat (40) @(posedge clk);
      #1;
      chk_seq("pkt4", b, 4, 32'hFCFC_FCFC, 32'h1111_2222, 32'h3333_4444, 32'hDCDC_0004);
      chk("pkt4_done_cnt", 32'(pkt_cnt - p), 32'd1);
      chk("pkt4_done_word", last_pkt_word, 32'hDCDC_0004);

      // Odd length: last word padded.
      b = seen.size();
      send(16'hAAAA, 0); send(16'hBBBB, 0); send(16'hCCCC, 1);
      repeat (40) @(posedge clk);
      #1;
      chk_seq("pkt3", b, 4, 32'hFCFC_FCFC, 32'hAAAA_BBBB, 32'hCCCC_3C3C, 32'hDCDC_0003);

      // Source stall mid-packet.
      b = seen.size(); u = und_cnt;
      send(16'h5555, 0);
      repeat (20) @(posedge clk);
      #1;
      send(16'h6666, 1);
      repeat (40) @(posedge clk);
      #1;
      chk_seq("stall", b, 3, 32'hFCFC_FCFC, 32'h5555_6666, 32'hDCDC_0002, 32'h0);
      chk("stall_underrun", 32'(und_cnt - u > 0), 32'd1);

      // Enable gap of 13 cycles mid-packet.
      b = seen.size();
      send(16'h7777, 0);
      wait_strobe();
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1 enable = 1'b0;
      s = strobes;
      repeat (6) @(posedge clk);
      #1;
      chk("gap_ready", 32'(bus.hw_ready), 32'd0);
      repeat (7) @(posedge clk);
      #1;
      chk("gap_strobes", 32'(strobes - s), 32'd0);
      enable = 1'b1;
      send(16'h8888, 0); send(16'h9999, 0); send(16'hAAAA, 1);
      repeat (40) @(posedge clk);
      #1;
      chk_seq("gap", b, 4, 32'hFCFC_FCFC, 32'h7777_8888, 32'h9999_AAAA, 32'hDCDC_0004);

      // Reset pulse mid-packet discards the partial packet.
      send(16'hBBBB, 0); send(16'hCCCC, 0);
      wait_strobe();
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("midrst_data_out", bus.data_out, IDLE_WORD);
      chk("midrst_data_v", 32'(bus.data_v), 32'd0);
      b = seen.size(); p = pkt_cnt;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("midrst_no_eof", 32'(pkt_cnt - p), 32'd0);
      chk("midrst_no_words", 32'(seen.size() - b), 32'd0);
      b = seen.size();
      send(16'hDDDD, 1);
      repeat (40) @(posedge clk);
      #1;
      chk_seq("after_rst", b, 3, 32'hFCFC_FCFC, 32'hDDDD_3C3C, 32'hDCDC_0001, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
